// File: rtl/linescan_pkg.sv
// Shared types and elaboration helpers for the linescan sensor controller.
//   linescan_state_t : frame sequencer states
//   pix_cnt_w()      : width of the pixel counter (covers 0..NUM_PIXELS)
//   half_cnt_w()     : width of the half-period counter (covers 0..CLK_HALF_NCLK-1)
//   strobe_offset_ok : the sample strobe must land inside one CLK period
package linescan_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSi,
        StReadout,
        StTail,
        StExpose
    } linescan_state_t;

    // Sample offset is limited to one full CLK period (two half periods).
    localparam int unsigned StbOffsetHalves = 2;

    function automatic int unsigned pix_cnt_w(input int unsigned num_pixels);
        return $clog2(num_pixels + 1);
    endfunction

    function automatic int unsigned half_cnt_w(input int unsigned half_nclk);
        return (half_nclk > 1) ? $clog2(half_nclk) : 1;
    endfunction

    function automatic bit strobe_offset_ok(input int unsigned offset,
                                            input int unsigned half_nclk);
        return offset < StbOffsetHalves * half_nclk;
    endfunction

endpackage

// File: rtl/linescan_clk_div.sv
// Half-period counter for the sensor clock.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : count enable
//   clr_i        : synchronous restart; next cycle is count 0 of a high half
//   high_o       : current half is the CLK-high half
//   cnt_o        : position inside the current half (0..CLK_HALF_NCLK-1)
//   rise_stb_o   : last cycle of a low half (CLK rises next)
//   fall_stb_o   : last cycle of a high half (CLK falls next)
module linescan_clk_div
    import linescan_pkg::*;
#(
    parameter int unsigned CLK_HALF_NCLK = 100,
    parameter int unsigned CntW          = half_cnt_w(CLK_HALF_NCLK)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            clr_i,
    output logic            high_o,
    output logic [CntW-1:0] cnt_o,
    output logic            rise_stb_o,
    output logic            fall_stb_o
);

    localparam logic [CntW-1:0] CntLast = CntW'(CLK_HALF_NCLK - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            high_q, high_d;
    logic            half_end;

    assign half_end = en_i && (cnt_q == CntLast);

    always_comb begin
        cnt_d  = cnt_q;
        high_d = high_q;
        if (clr_i) begin
            cnt_d  = '0;
            high_d = 1'b1;
        end else if (en_i) begin
            if (cnt_q == CntLast) begin
                cnt_d  = '0;
                high_d = ~high_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            high_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            high_q <= high_d;
        end
    end

    assign high_o     = high_q;
    assign cnt_o      = cnt_q;
    assign rise_stb_o = half_end && !high_q;
    assign fall_stb_o = half_end && high_q;

endmodule

// File: rtl/linescan_sensor_ctrl.sv
// Timing controller for TSL1401-class linear sensors (CJMCU-1401).
// Generates SI/CLK readout, per-pixel ADC sample strobe with index, and extra exposure.
//   master_clock_i / master_reset_i : clock, asynchronous active-high reset
//   start_i             : frame request (ignored while busy)
//   continuous_i        : restart immediately at frame end
//   sensor_enable_i     : per-sensor enable, latched at frame start
//   exposure_ncycles_i  : extra integration cycles, latched at frame start
//   busy_o, frame_done_o, sample_capture_trigger_o, pixel_index_o
//   cjmcu1401_si_o / cjmcu1401_clk_o : sensor pins, driven straight from flops
// Build option: LINESCAN_TAIL_CLK_EN adds the terminating CLK period after the last pixel.
//
// The sequencer runs one cycle ahead of the pins: the state in cycle t decides
// what every output register shows in cycle t+1.
module linescan_sensor_ctrl
    import linescan_pkg::*;
#(
    parameter int unsigned NUM_PIXELS         = 128,
    parameter int unsigned NUM_SENSORS        = 1,
    parameter int unsigned CLK_HALF_NCLK      = 100,
    parameter int unsigned SI_HIGH_NCLK       = 4,
    parameter int unsigned SAMPLE_OFFSET_NCLK = 35,
    parameter int unsigned EXPOSURE_W         = 32
) (
    input  logic                          master_clock_i,
    input  logic                          master_reset_i,
    input  logic                          start_i,
    input  logic                          continuous_i,
    input  logic [NUM_SENSORS-1:0]        sensor_enable_i,
    input  logic [EXPOSURE_W-1:0]         exposure_ncycles_i,
    output logic                          busy_o,
    output logic                          sample_capture_trigger_o,
    output logic [$clog2(NUM_PIXELS)-1:0] pixel_index_o,
    output logic                          frame_done_o,
    output logic [NUM_SENSORS-1:0]        cjmcu1401_si_o,
    output logic [NUM_SENSORS-1:0]        cjmcu1401_clk_o
);

    localparam int unsigned PixW  = pix_cnt_w(NUM_PIXELS);
    localparam int unsigned IdxW  = $clog2(NUM_PIXELS);
    localparam int unsigned HalfW = half_cnt_w(CLK_HALF_NCLK);

    localparam logic [HalfW-1:0] SiLast  = HalfW'(SI_HIGH_NCLK / 2 - 1);
    localparam logic [PixW-1:0]  PixLast = PixW'(NUM_PIXELS - 1);
`ifdef LINESCAN_TAIL_CLK_EN
    localparam logic [PixW-1:0]  PixTail = PixW'(NUM_PIXELS);
`endif
    // SI stays high into the first CLK-high half for the remainder of its width.
    localparam int unsigned SiReadoutCycles = SI_HIGH_NCLK - SI_HIGH_NCLK / 2;
    localparam bit          StbInHigh       = SAMPLE_OFFSET_NCLK < CLK_HALF_NCLK;
    localparam logic [HalfW-1:0] StbCnt =
        HalfW'(StbInHigh ? SAMPLE_OFFSET_NCLK : SAMPLE_OFFSET_NCLK - CLK_HALF_NCLK);

    if (SI_HIGH_NCLK < 2) begin : g_chk_si_min
        $error("SI_HIGH_NCLK must be at least 2");
    end
    if (SI_HIGH_NCLK / 2 >= CLK_HALF_NCLK) begin : g_chk_si_half
        $error("SI_HIGH_NCLK/2 must be below CLK_HALF_NCLK");
    end
    if (!strobe_offset_ok(SAMPLE_OFFSET_NCLK, CLK_HALF_NCLK)) begin : g_chk_offset
        $error("SAMPLE_OFFSET_NCLK must be below 2*CLK_HALF_NCLK");
    end
    if (NUM_PIXELS < 2) begin : g_chk_pixels
        $error("NUM_PIXELS must be at least 2");
    end

    linescan_state_t         state_q, state_d;
    logic [PixW-1:0]         pix_q, pix_d;
    logic [HalfW-1:0]        si_cnt_q, si_cnt_d;
    logic [EXPOSURE_W-1:0]   exp_cnt_q, exp_cnt_d;
    logic [EXPOSURE_W-1:0]   exp_q, exp_d;
    logic [NUM_SENSORS-1:0]  ena_q, ena_d;

    logic                    busy_q, busy_d;
    logic                    stb_q, stb_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    done_q, done_d;
    logic [NUM_SENSORS-1:0]  si_q, si_d;
    logic [NUM_SENSORS-1:0]  clk_q, clk_d;

    logic                    div_en, div_clr, div_high, div_rise_stb, div_fall_stb;
    logic [HalfW-1:0]        div_cnt;
    logic                    start_acc, line_end, frame_end, stb_hit;
    logic                    unused_fall_stb;

    assign unused_fall_stb = div_fall_stb;

    linescan_clk_div #(
        .CLK_HALF_NCLK (CLK_HALF_NCLK),
        .CntW          (HalfW)
    ) u_clk_div (
        .clk_i      (master_clock_i),
        .rst_i      (master_reset_i),
        .en_i       (div_en),
        .clr_i      (div_clr),
        .high_o     (div_high),
        .cnt_o      (div_cnt),
        .rise_stb_o (div_rise_stb),
        .fall_stb_o (div_fall_stb)
    );

    assign stb_hit = (div_high == StbInHigh) && (div_cnt == StbCnt);

    // Next-state
    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        si_cnt_d  = si_cnt_q;
        exp_cnt_d = exp_cnt_q;
        exp_d     = exp_q;
        ena_d     = ena_q;
        div_en    = 1'b0;
        div_clr   = 1'b0;
        start_acc = 1'b0;
        line_end  = 1'b0;
        frame_end = 1'b0;

        unique case (state_q)
            StIdle: begin
                // busy_q still covers the frame_done cycle right after a frame
                if (start_i && !busy_q) begin
                    start_acc = 1'b1;
                    state_d   = StSi;
                    si_cnt_d  = '0;
                    ena_d     = sensor_enable_i;
                    exp_d     = exposure_ncycles_i;
                end
            end
            StSi: begin
                div_clr = 1'b1;
                if (si_cnt_q == SiLast) begin
                    state_d  = StReadout;
                    si_cnt_d = '0;
                    pix_d    = '0;
                end else begin
                    si_cnt_d = si_cnt_q + HalfW'(1);
                end
            end
            StReadout: begin
                div_en = 1'b1;
                if (div_rise_stb) begin
                    if (pix_q == PixLast) begin
`ifdef LINESCAN_TAIL_CLK_EN
                        pix_d   = PixTail;
                        state_d = StTail;
`else
                        line_end = 1'b1;
`endif
                    end else begin
                        pix_d = pix_q + PixW'(1);
                    end
                end
            end
`ifdef LINESCAN_TAIL_CLK_EN
            StTail: begin
                div_en = 1'b1;
                if (div_rise_stb) begin
                    line_end = 1'b1;
                end
            end
`endif
            StExpose: begin
                if (exp_cnt_q == exp_q - EXPOSURE_W'(1)) begin
                    frame_end = 1'b1;
                end else begin
                    exp_cnt_d = exp_cnt_q + EXPOSURE_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Zero exposure: the last CLK-low cycle is also the frame_done cycle.
        if (line_end) begin
            pix_d = '0;
            if (exp_q == '0) begin
                frame_end = 1'b1;
            end else begin
                state_d   = StExpose;
                exp_cnt_d = '0;
            end
        end

        if (frame_end) begin
            exp_cnt_d = '0;
            if (continuous_i) begin
                state_d  = StSi;
                si_cnt_d = '0;
                ena_d    = sensor_enable_i;
                exp_d    = exposure_ncycles_i;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Output next values, decoded from the current sequencer position
    always_comb begin
        si_d   = '0;
        clk_d  = '0;
        stb_d  = 1'b0;
        idx_d  = '0;
        done_d = frame_end;
        busy_d = (state_q != StIdle) || start_acc;

        unique case (state_q)
            StSi: begin
                si_d = ena_q;
            end
            StReadout: begin
                if (div_high) begin
                    clk_d = ena_q;
                end
                if ((pix_q == '0) && div_high && (32'(div_cnt) < SiReadoutCycles)) begin
                    si_d = ena_q;
                end
                if (stb_hit) begin
                    stb_d = 1'b1;
                    idx_d = pix_q[IdxW-1:0];
                end
            end
            StTail: begin
                if (div_high) begin
                    clk_d = ena_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge master_clock_i or posedge master_reset_i) begin
        if (master_reset_i) begin
            state_q   <= StIdle;
            pix_q     <= '0;
            si_cnt_q  <= '0;
            exp_cnt_q <= '0;
            exp_q     <= '0;
            ena_q     <= '0;
            busy_q    <= 1'b0;
            stb_q     <= 1'b0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            si_q      <= '0;
            clk_q     <= '0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            si_cnt_q  <= si_cnt_d;
            exp_cnt_q <= exp_cnt_d;
            exp_q     <= exp_d;
            ena_q     <= ena_d;
            busy_q    <= busy_d;
            stb_q     <= stb_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            si_q      <= si_d;
            clk_q     <= clk_d;
        end
    end

    assign busy_o                   = busy_q;
    assign sample_capture_trigger_o = stb_q;
    assign pixel_index_o            = idx_q;
    assign frame_done_o             = done_q;
    assign cjmcu1401_si_o           = si_q;
    assign cjmcu1401_clk_o          = clk_q;

endmodule

// File: tb/tb_linescan_sensor_ctrl.sv
// Directed bench for linescan_sensor_ctrl (NUM_PIXELS=8, CLK_HALF_NCLK=4, SI_HIGH_NCLK=2,
// SAMPLE_OFFSET_NCLK=3, two sensors). Follows LINESCAN_TAIL_CLK_EN for the expected tail.
module tb_linescan_sensor_ctrl;

    localparam int unsigned NP     = 8;
    localparam int unsigned HC     = 4;
    localparam int unsigned SH     = 2;
    localparam int unsigned SO     = 3;
    localparam int unsigned NS     = 2;
    localparam int unsigned PERIOD = 2 * HC;
`ifdef LINESCAN_TAIL_CLK_EN
    localparam int unsigned TAIL = 1;
`else
    localparam int unsigned TAIL = 0;
`endif

    // Frame length from first SI-high cycle to frame_done inclusive:
    // 83 with tail and exposure 10, 75 without tail.
    function automatic int frame_len(input int e);
        return SH / 2 + PERIOD * (NP + TAIL) + e;
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [NS-1:0] enable = '0;
    logic [31:0]   exposure = '0;
    logic          busy, stb, done;
    logic [2:0]    idx;
    logic [NS-1:0] si, sclk;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    linescan_sensor_ctrl #(
        .NUM_PIXELS         (NP),
        .NUM_SENSORS        (NS),
        .CLK_HALF_NCLK      (HC),
        .SI_HIGH_NCLK       (SH),
        .SAMPLE_OFFSET_NCLK (SO),
        .EXPOSURE_W         (32)
    ) dut (
        .master_clock_i           (clk),
        .master_reset_i           (rst),
        .start_i                  (start),
        .continuous_i             (continuous),
        .sensor_enable_i          (enable),
        .exposure_ncycles_i       (exposure),
        .busy_o                   (busy),
        .sample_capture_trigger_o (stb),
        .pixel_index_o            (idx),
        .frame_done_o             (done),
        .cjmcu1401_si_o           (si),
        .cjmcu1401_clk_o          (sclk)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic expect_idle(input string tag, input int ncyc);
        int act;
        act = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (busy || done || stb || (si != '0) || (sclk != '0)) act++;
        end
        check(tag, act, 0);
    endtask

    // One single-shot frame; optionally pokes start/params mid-readout.
    task automatic run_frame(input string tag, input int expo, input logic [NS-1:0] mask,
                             input bit poke);
        int            si_pos, pos, rises0, rises1, si0_hi, si1_hi, stb_n, done_pos, busy_low;
        logic [NS-1:0] clk_prev;
        bit            seen;
        si_pos = -1; pos = -1; rises0 = 0; rises1 = 0; si0_hi = 0; si1_hi = 0;
        stb_n = 0; done_pos = -1; busy_low = 0; clk_prev = '0; seen = 1'b0;

        @(negedge clk);
        start = 1'b1; exposure = 32'(expo); enable = mask;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (si[0] && si_pos < 0) si_pos = c;
            pos = (si_pos < 0) ? -1 : c - si_pos;
            if (c == 0) check({tag, "_busy_rise"}, int'(busy), 1);
            if (!busy) busy_low++;
            if (si[0]) si0_hi++;
            if (si[1]) si1_hi++;
            if (sclk[0] && !clk_prev[0]) begin
                rises0++;
                if (rises0 == 1) check({tag, "_first_rise_pos"}, pos, 1);
            end
            if (sclk[1] && !clk_prev[1]) rises1++;
            clk_prev = sclk;
            if (stb) begin
                if (stb_n < int'(NP)) begin
                    check({tag, "_stb_idx"}, int'(idx), stb_n);
                    check({tag, "_stb_pos"}, pos, 4 + 8 * stb_n);
                end
                stb_n++;
            end
            if (done) begin
                seen = 1'b1;
                done_pos = pos;
            end
            start = poke && (c == 30);
            if (poke && c == 30) begin
                exposure = 32'd3;
                enable = ~mask;
            end
        end
        check({tag, "_done_seen"}, int'(seen), 1);
        check({tag, "_done_pos"}, done_pos, frame_len(expo) - 1);
        check({tag, "_rises0"}, rises0, NP + TAIL);
        check({tag, "_rises1"}, rises1, mask[1] ? NP + TAIL : 0);
        check({tag, "_si0_cycles"}, si0_hi, SH);
        check({tag, "_si1_cycles"}, si1_hi, mask[1] ? SH : 0);
        check({tag, "_strobes"}, stb_n, NP);
        check({tag, "_busy_held"}, busy_low, 0);
        @(negedge clk);
        check({tag, "_busy_fall"}, int'(busy), 0);
        expect_idle({tag, "_idle_after"}, 20);
    endtask

    task automatic run_continuous();
        int dones, last_done, busy_low, f0;
        bit prev_done;
        dones = 0; last_done = -1; busy_low = 0; prev_done = 1'b0; f0 = frame_len(0);
        continuous = 1'b1;
        @(negedge clk);
        start = 1'b1; exposure = 32'd0; enable = 2'b11;
        for (int c = 0; c < 4 * f0 && dones < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) busy_low++;
            if (prev_done) check("cont_si_after_done", int'(si[0]), 1);
            prev_done = done;
            if (done) begin
                dones++;
                if (last_done >= 0) check("cont_period", c - last_done, f0);
                last_done = c;
                if (dones == 2) continuous = 1'b0;
            end
        end
        check("cont_dones", dones, 3);
        check("cont_busy_held", busy_low, 0);
        @(negedge clk);
        check("cont_stop_busy", int'(busy), 0);
        check("cont_stop_si", int'(si[0]), 0);
        expect_idle("cont_idle", 20);
    endtask

    task automatic run_reset_mid();
        bit found;
        found = 1'b0;
        @(negedge clk);
        start = 1'b1; exposure = 32'd10; enable = 2'b11;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (stb && idx == 3'd4) found = 1'b1;
        end
        check("rst_reach_pix4", int'(found), 1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", int'({busy, stb, done, idx, si, sclk}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_idle("rst_stay_idle", 20);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({busy, stb, done, idx, si, sclk}), 0);
        rst = 1'b0;
        expect_idle("idle_no_start", 10);
        run_frame("single", 10, 2'b11, 1'b0);
        run_frame("mask", 10, 2'b01, 1'b0);
        run_frame("busy_start", 10, 2'b11, 1'b1);
        run_frame("expo0", 0, 2'b11, 1'b0);
        run_continuous();
        run_reset_mid();
        run_frame("post_rst", 10, 2'b11, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/linescan_sensor_ctrl.md
# linescan_sensor_ctrl

Parametrised timing controller for one or more TSL1401-class linear image sensors (CJMCU-1401 boards). It generates the SI/CLK readout sequence, the per-pixel ADC sample-capture strobe with a pixel index, and a programmable extra integration time. It supports single-shot and continuous frame modes. It sits between the ADC capture path, which consumes the sample strobe and index, and the sensor I/O pins.

## Interface
- `NUM_PIXELS`, 128: pixels per sensor line.
- `NUM_SENSORS`, 1: sensors driven in lockstep.
- `CLK_HALF_NCLK`, 100: sensor clock half-period, in master_clock cycles.
- `SI_HIGH_NCLK`, 4: SI pulse width, in master cycles.
- `SAMPLE_OFFSET_NCLK`, 35: delay from a sensor CLK rising edge to the sample strobe.
- `EXPOSURE_W`, 32: width of the exposure input.
- `master_clock` in 1: 100 MHz clock.
- `master_reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle frame request; ignored while `busy`.
- `continuous` in 1: level; sampled at frame end.
- `sensor_enable` in NUM_SENSORS: per-sensor enable mask; latched at frame start.
- `exposure_ncycles` in EXPOSURE_W: extra integration time; latched at frame start.
- `busy` out 1: a frame is in progress.
- `sample_capture_trigger` out 1: one-cycle ADC sample strobe.
- `pixel_index` out $clog2(NUM_PIXELS): index of the pixel being sampled; valid with the strobe.
- `frame_done` out 1: one-cycle pulse at frame end.
- `cjmcu1401_si` out NUM_SENSORS: sensor SI pins; IOB registers.
- `cjmcu1401_clk` out NUM_SENSORS: sensor CLK pins; IOB registers.

## Operation
- FSM states: IDLE → SI → READOUT → [TAIL] → EXPOSE → IDLE, or → SI when continuous.
- IDLE
  - All outputs low.
  - `start` high: latch `sensor_enable` and `exposure_ncycles`, then go to SI. `busy` rises in the next cycle.
- SI
  - SI is high for SI_HIGH_NCLK cycles.
  - The first CLK rising edge occurs SI_HIGH_NCLK/2 cycles (integer division) after SI rises.
  - Then go to READOUT.
- READOUT
  - CLK toggles every CLK_HALF_NCLK cycles.
  - Rising edge k (k = 0..NUM_PIXELS-1) is followed, SAMPLE_OFFSET_NCLK cycles later, by one `sample_capture_trigger` cycle with `pixel_index` = k.
  - After falling edge NUM_PIXELS-1, go to TAIL, or to EXPOSE when TAIL is compiled out.
- TAIL
  - One extra CLK period (edge NUM_PIXELS) that terminates the sensor's output cycle.
  - No strobe is issued.
- EXPOSE
  - CLK and SI held low for the latched `exposure_ncycles` cycles. A value of 0 leaves EXPOSE immediately.
  - `frame_done` pulses in the leaving cycle.
  - Then `continuous` = 1 → SI directly with fresh latches. Otherwise → IDLE.
- Disabled sensors: their SI and CLK bits are held 0 for the whole frame. Strobes are still generated.
- `start` while `busy`: ignored. Frame parameter changes mid-frame are not seen until the next latch.
- `master_reset` asserted at any time: state → IDLE, all counters 0, all outputs 0, immediately (asynchronous). The first frame after reset requires `start`.
- Counters saturate nowhere. The pixel counter covers 0..NUM_PIXELS and the half-period counter covers 0..CLK_HALF_NCLK-1.
- Elaboration asserts the following:
  - SI_HIGH_NCLK ≥ 2
  - SI_HIGH_NCLK/2 < CLK_HALF_NCLK
  - SAMPLE_OFFSET_NCLK < 2·CLK_HALF_NCLK
  - NUM_PIXELS ≥ 2

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Frame length F, measured from the first SI-high cycle to `frame_done` inclusive: F = SI_HIGH_NCLK/2 + 2·CLK_HALF_NCLK·(NUM_PIXELS + T) + exposure_ncycles, where T = 1 if TAIL is present, else 0.
- In continuous mode, SI rises in the cycle after `frame_done`.
- `busy` is high from the cycle after `start` is accepted through the `frame_done` cycle. It stays high across back-to-back continuous frames.
- Strobe spacing is exactly 2·CLK_HALF_NCLK cycles.

## Configuration
- Macro `LINESCAN_TAIL_CLK_EN`.
  - Defined: the TAIL state emits the extra CLK period (edge NUM_PIXELS+1 of the frame) required by the TSL1401.
  - Undefined: TAIL is removed, and READOUT goes directly to EXPOSE.

## Structure
- `linescan_pkg`: state enum `linescan_state_t`, width helper functions (pixel and half-counter widths), and the strobe-offset check constant.
- One sub-module, `linescan_clk_div`: the half-period counter. It exposes `rise_stb`/`fall_stb` and has an enable. The FSM, strobe logic and output registers live in the top level.

## Test plan
Unless stated otherwise, tests use NUM_PIXELS=8, CLK_HALF_NCLK=4, SI_HIGH_NCLK=2, SAMPLE_OFFSET_NCLK=3.
- **Single frame:** `start`, exposure=10, macro defined → 9 CLK rising edges; 8 strobes with `pixel_index` 0..7 spaced 8 cycles apart; first strobe 3 cycles after the first CLK rise; `frame_done` 83 cycles after SI rises; then IDLE.
- **No macro:** the same stimulus without `LINESCAN_TAIL_CLK_EN` → 8 rising edges, 8 strobes, `frame_done` after 75 cycles.
- **Continuous:** `continuous`=1, exposure=0 → SI re-rises in the cycle after each `frame_done`; `busy` never drops across 3 frames. Deasserting `continuous` → IDLE after the current frame.
- **Masking:** `sensor_enable`=2'b01 with NUM_SENSORS=2 → bit 1 of SI/CLK stays 0; bit 0 runs; all 8 strobes are present.
- **Start during busy:** `start` pulsed during READOUT → ignored; exactly one `frame_done`.
- **Reset mid-frame:** `master_reset` asserted at pixel 4 → all outputs 0 in the same cycle; after release, the block stays IDLE until `start`; the next frame starts at `pixel_index` 0.
